// File: rtl/div_restaurador_8bits_pkg.sv
// Shared encodings and constants for the 8-bit restoring divider.
// Kept separate so the FSM and any future display logic agree on them.
package div_restaurador_8bits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] ITER_LAST     = 3'd7;
  localparam logic [7:0] DIV0_QUOTIENT = 8'hFF;

endpackage

// File: rtl/SubComp8bits.sv
// Combinational 8-bit ripple-borrow subtractor: S = A - B - Bin.
// Bout is the borrow out of the MSB, i.e. set when A < B + Bin.
module SubComp8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bin,
  output logic [7:0] S,
  output logic       Bout
);

  logic [8:0] borrow;

  assign borrow[0] = Bin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_stage
      assign S[gi]        = A[gi] ^ B[gi] ^ borrow[gi];
      assign borrow[gi+1] = (~A[gi] & B[gi]) | (~(A[gi] ^ B[gi]) & borrow[gi]);
    end
  endgenerate

  assign Bout = borrow[8];

endmodule

// File: rtl/div_restaurador_8bits.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Trial subtraction is done by SubComp8bits; FSM and shift registers live here.
module div_restaurador_8bits
  import div_restaurador_8bits_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] dividend,
  input  logic [N_BITS-1:0] divisor,
  output logic [N_BITS-1:0] quotient,
  output logic [N_BITS-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  state_t state_reg, state_next;

  logic [N_BITS-1:0] q_reg, q_next;
  logic [N_BITS-1:0] r_reg, r_next;
  logic [N_BITS-1:0] d_reg, d_next;
  logic [2:0]        count_reg, count_next;
  logic [N_BITS-1:0] quo_reg, quo_next;
  logic [N_BITS-1:0] rem_reg, rem_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              dz_reg, dz_next;

  // R stays below 2^i before shift i, so the shifted value always fits in 8 bits.
  logic [N_BITS-1:0] r_shift;
  logic [N_BITS-1:0] diff;
  logic              borrow_out;

  assign r_shift = {r_reg[N_BITS-2:0], q_reg[N_BITS-1]};

  SubComp8bits u_sub (
    .A    (r_shift),
    .B    (d_reg),
    .Bin  (1'b0),
    .S    (diff),
    .Bout (borrow_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (count_reg == ITER_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the state, so they trail it by one cycle.
  always_comb begin
    q_next     = q_reg;
    r_next     = r_reg;
    d_next     = d_reg;
    count_next = count_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
    busy_next  = (state_reg == ST_CALC);
    done_next  = (state_reg == ST_DONE);

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          count_next = '0;
          d_next     = divisor;
          if (divisor == '0) begin
            q_next  = DIV0_QUOTIENT;
            r_next  = dividend;
            dz_next = 1'b1;
          end else begin
            q_next  = dividend;
            r_next  = '0;
            dz_next = 1'b0;
          end
        end
      end
      ST_CALC: begin
        if (!borrow_out) begin
          r_next = diff;
          q_next = {q_reg[N_BITS-2:0], 1'b1};
        end else begin
          r_next = r_shift;
          q_next = {q_reg[N_BITS-2:0], 1'b0};
        end
        count_next = count_reg + 3'd1;
      end
      ST_DONE: begin
        quo_next = q_reg;
        rem_next = r_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      q_reg     <= q_next;
      r_reg     <= r_next;
      d_reg     <= d_next;
      count_reg <= count_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      dz_reg    <= dz_next;
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign div_zero  = dz_reg;

endmodule

// File: doc/div_restaurador_8bits.md
Name: div_restaurador_8bits

Overview:
- Sequential 8-bit unsigned restoring divider.
- Iterates one quotient bit per clock using the team's combinational 8-bit ripple-borrow subtractor SubComp8bits as its only arithmetic datapath.
- Direct consumer of that subtractor: drives its A/B/Bin, consumes S and Bout.
- Sits between the operand-entry logic and the result display/register stage; start/busy/done handshake to both.

Parameters:
- N_BITS, 8, operand width. Fixed at 8, matching the subtractor width; other values unsupported.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  8  unsigned dividend, sampled with start.
- divisor  input  8  unsigned divisor, sampled with start.
- quotient  output  8  result quotient.
- remainder  output  8  result remainder.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: result valid.
- div_zero  output  1  divisor was 0 on the last accepted start.

Behaviour:
- Reset: one clock, synchronous, active-low, applied at a rising edge with rst_n=0. All regs clear; quotient=0, remainder=0, busy=0, done=0, div_zero=0; state=IDLE; count=0.
- Reset mid-operation aborts the division with no done pulse; start is ignored that cycle.
- States:
  - IDLE: start=1 with divisor!=0 → latch Q=dividend, D=divisor, R=0, count=0, div_zero=0 → CALC. start=1 with divisor=0 → quotient=8'hFF, remainder=dividend, div_zero=1 → DONE.
  - CALC: busy=1. R'={R[6:0],Q[7]}. Subtractor gets A=R', B=D, Bin=0. If Bout=0: R←S, Q←{Q[6:0],1}; else R←R', Q←{Q[6:0],0}. count++. After 8th iteration (count=7) → DONE.
  - DONE: done=1 for exactly one cycle; quotient/remainder drive final Q/R → IDLE.
- R < 2^i before shift i, so R' never exceeds 8 bits; no 9th remainder bit is needed.
- Latency: start sampled at edge k; busy=1 after edges k+1..k+8; done=1 after edge k+9 (10 cycles start-to-done). Divide-by-zero: done after edge k+1.
- quotient/remainder/div_zero hold their values from DONE until the next accepted start. During CALC they are not guaranteed; the bench must not check them.
- start while busy or in DONE: ignored, no queuing. dividend/divisor may change after acceptance without effect.
- start held high continuously: a new division is accepted in the IDLE cycle after each DONE.
- busy and done are never high in the same cycle.

Decomposition:
- Shared package/include: state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2; ITER_LAST=3'd7; DIV0_QUOTIENT=8'hFF.
- One sub-module: instantiate existing SubComp8bits for the trial subtraction, with Bin tied to 0. Do not write a new subtractor.
- FSM, shift registers and counter live in div_restaurador_8bits.

Test Plan:
- Reset, then start dividend=200, divisor=7 → done 10 cycles later; quotient=28, remainder=4, div_zero=0; busy high exactly 8 cycles.
- Edge values: 255/1 → q=255, r=0. 255/255 → q=1, r=0. 5/10 → q=0, r=5. 0/3 → q=0, r=0.
- 100/0 → done after 2 cycles, quotient=8'hFF, remainder=100, div_zero=1, busy never high. Then 9/2 → q=4, r=1, div_zero=0.
- Pulse start again at busy cycle 3 with different operands while computing 200/7 → ignored; result still 28 r4; no extra done pulse.
- Assert rst_n=0 at busy cycle 4, release, then 77/8 → no done for the aborted op; all outputs 0 after reset; then q=9, r=5.
- start held high with 50/6 → back-to-back results q=8, r=2, with done every 10 cycles; outputs stable between done pulses.
